// File: rtl/lector_display_7seg.sv
// Seven-segment display reader: recovers the hex digits shown on a multiplexed,
// active-low segment/anode bus and publishes complete frames with a valid pulse.
module lector_display_7seg #(
   parameter int P_DIGITOS = 4,
   parameter int P_ESTABLE = 16
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_n,
   input  logic [6:0]             i_Segmentos,
   input  logic [P_DIGITOS-1:0]   i_Anodos,
   output logic [4*P_DIGITOS-1:0] o_Digitos,
   output logic                   o_Valido,
   output logic [P_DIGITOS-1:0]   o_Error
);

   localparam int CW = $clog2(P_ESTABLE + 1);
   localparam logic [CW-1:0] C_MAX = CW'(P_ESTABLE);
   localparam logic [CW-1:0] C_PRE = CW'(P_ESTABLE - 1);

   logic [P_DIGITOS-1:0]   anod_s1_r;
   logic [P_DIGITOS-1:0]   anod_s2_r;
   logic [P_DIGITOS-1:0]   anod_prev_r;
   logic [6:0]             seg_s1_r;
   logic [6:0]             seg_s2_r;
   logic [6:0]             seg_prev_r;
   logic [CW-1:0]          cnt_r;
   logic [P_DIGITOS-1:0]   mask_r;
   logic [4*P_DIGITOS-1:0] work_r;

   logic                   same_s;
   logic                   capture_s;
   logic                   done_s;
   logic [4:0]             dec_s;
   logic [CW-1:0]          cnt_next_s;
   logic [P_DIGITOS-1:0]   cap_bits_s;
   logic [P_DIGITOS-1:0]   seen_s;
   logic [P_DIGITOS-1:0]   mask_next_s;
   logic [P_DIGITOS-1:0]   err_next_s;
   logic [4*P_DIGITOS-1:0] work_next_s;

   // Returns {valid, code}; valid is low for any pattern that is not a hex glyph.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'b0000001: res = {1'b1, 4'h0};
         7'b1001111: res = {1'b1, 4'h1};
         7'b0010010: res = {1'b1, 4'h2};
         7'b0000110: res = {1'b1, 4'h3};
         7'b1001100: res = {1'b1, 4'h4};
         7'b0100100: res = {1'b1, 4'h5};
         7'b0100000: res = {1'b1, 4'h6};
         7'b0001111: res = {1'b1, 4'h7};
         7'b0000000: res = {1'b1, 4'h8};
         7'b0001100: res = {1'b1, 4'h9};
         7'b0001000: res = {1'b1, 4'hA};
         7'b1100000: res = {1'b1, 4'hB};
         7'b0110001: res = {1'b1, 4'hC};
         7'b1000010: res = {1'b1, 4'hD};
         7'b0110000: res = {1'b1, 4'hE};
         7'b0111000: res = {1'b1, 4'hF};
         default:    res = {1'b0, 4'h0};
      endcase
      return res;
   endfunction

   // True when exactly one active-low enable is asserted.
   function automatic logic one_low(input logic [P_DIGITOS-1:0] anod);
      logic [P_DIGITOS-1:0] inv;
      inv = ~anod;
      return (inv != '0) && ((inv & (inv - P_DIGITOS'(1))) == '0);
   endfunction

   // Two-flop synchronisers plus the delayed copy used for change detection.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         anod_s1_r   <= '1;
         anod_s2_r   <= '1;
         anod_prev_r <= '1;
         seg_s1_r    <= 7'h7F;
         seg_s2_r    <= 7'h7F;
         seg_prev_r  <= 7'h7F;
      end else begin
         anod_s1_r   <= i_Anodos;
         anod_s2_r   <= anod_s1_r;
         anod_prev_r <= anod_s2_r;
         seg_s1_r    <= i_Segmentos;
         seg_s2_r    <= seg_s1_r;
         seg_prev_r  <= seg_s2_r;
      end
   end

   // Settle counter, capture decision, working-frame merge and frame completion.
   always_comb begin
      same_s      = (anod_s2_r == anod_prev_r) && (seg_s2_r == seg_prev_r);
      cnt_next_s  = cnt_r;
      work_next_s = work_r;
      err_next_s  = o_Error;
      dec_s       = decode_seg(seg_s2_r);

      if (!same_s) begin
         cnt_next_s = '0;
      end else if (cnt_r == C_MAX) begin
         cnt_next_s = cnt_r;
      end else begin
         cnt_next_s = cnt_r + CW'(1);
      end

      capture_s = same_s && (cnt_r == C_PRE) && one_low(anod_s2_r);
      if (capture_s) begin
         cap_bits_s = ~anod_s2_r;
      end else begin
         cap_bits_s = '0;
      end

      for (int k = 0; k < P_DIGITOS; k++) begin
         if (cap_bits_s[k]) begin
            err_next_s[k] = ~dec_s[4];
            if (dec_s[4]) begin
               work_next_s[4*k +: 4] = dec_s[3:0];
            end else begin
               work_next_s[4*k +: 4] = work_r[4*k +: 4];
            end
         end else begin
            err_next_s[k] = o_Error[k];
         end
      end

      seen_s = mask_r | cap_bits_s;
      done_s = capture_s && (&seen_s);
      if (done_s) begin
         mask_next_s = '0;
      end else begin
         mask_next_s = seen_s;
      end
   end

   // State and registered outputs.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         cnt_r     <= '0;
         mask_r    <= '0;
         work_r    <= '0;
         o_Digitos <= '0;
         o_Valido  <= 1'b0;
         o_Error   <= '0;
      end else begin
         cnt_r    <= cnt_next_s;
         mask_r   <= mask_next_s;
         work_r   <= work_next_s;
         o_Error  <= err_next_s;
         o_Valido <= done_s;
         if (done_s) begin
            o_Digitos <= work_next_s;
         end else begin
            o_Digitos <= o_Digitos;
         end
      end
   end

   lector_display_7seg_chk #(
      .P_DIGITOS (P_DIGITOS),
      .P_ESTABLE (P_ESTABLE)
   ) u_chk (
      .clk     (i_Clk),
      .rst_n   (i_Rst_n),
      .valido  (o_Valido),
      .capture (capture_s),
      .anod    (anod_s2_r),
      .cnt     (cnt_r)
   );

endmodule

// Runtime properties of the reader: pulse spacing, counter range, capture legality.
module lector_display_7seg_chk #(
   parameter int P_DIGITOS = 4,
   parameter int P_ESTABLE = 16
) (
   input logic                               clk,
   input logic                               rst_n,
   input logic                               valido,
   input logic                               capture,
   input logic [P_DIGITOS-1:0]               anod,
   input logic [$clog2(P_ESTABLE + 1)-1:0]   cnt
);

   localparam int CW = $clog2(P_ESTABLE + 1);

   a_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
      valido |=> !valido);

   a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
      cnt <= CW'(P_ESTABLE));

   a_capture_one_hot: assert property (@(posedge clk) disable iff (!rst_n)
      capture |-> $onehot(~anod));

endmodule

// File: tb/tb_lector_display_7seg.sv
// Directed bench for lector_display_7seg: scans hand-built digit patterns and
// checks frames, latency, error flags, glitch and reset behaviour.
module tb_lector_display_7seg;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  anod;
   logic [15:0] digitos;
   logic        valido;
   logic [3:0]  error;

   int n_tests = 0;
   int n_fail  = 0;
   int vcount  = 0;
   int dbl     = 0;
   logic prev_v = 1'b0;
   int lat;

   logic [6:0] seg_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   lector_display_7seg #(
      .P_DIGITOS (4),
      .P_ESTABLE (16)
   ) dut (
      .i_Clk       (clk),
      .i_Rst_n     (rst_n),
      .i_Segmentos (seg),
      .i_Anodos    (anod),
      .o_Digitos   (digitos),
      .o_Valido    (valido),
      .o_Error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counter, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valido === 1'b1) begin
         vcount++;
         if (prev_v) dbl++;
      end
      prev_v = (rst_n === 1'b1) && (valido === 1'b1);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s);
      @(negedge clk);
      anod = a;
      seg  = s;
   endtask

   function automatic logic [3:0] sel(input int k);
      logic [3:0] a;
      a = 4'b1111;
      a[k] = 1'b0;
      return a;
   endfunction

   // Show glyph value v on digit k for 'dwell' sampling edges.
   task automatic scan(input int k, input int v, input int dwell);
      drive(sel(k), seg_tab[v]);
      repeat (dwell) @(posedge clk);
   endtask

   // Edge 0 is the first edge sampling the just-driven pattern; returns the
   // index of the edge after which o_Valido is first seen high (-1 if never).
   task automatic meas_lat(output int l);
      l = -1;
      for (int i = 0; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (valido && l < 0) l = i;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      seg   = 7'h7F;
      anod  = 4'hF;

      // Reset with a noisy bus.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seg  = 7'($urandom);
         anod = 4'($urandom);
      end
      #1;
      chk("rst_digitos", 32'(digitos), 32'h0);
      chk("rst_valido", 32'(valido), 32'h0);
      chk("rst_error", 32'(error), 32'h0);

      // Release with blank bus: nothing may be captured.
      drive(4'hF, 7'h7F);
      rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("idle_vcount", 32'(vcount), 32'd0);
      chk("idle_digitos", 32'(digitos), 32'h0);
      chk("idle_error", 32'(error), 32'h0);

      // Frame 1,2,3,4 with latency check on the final digit.
      scan(0, 1, 40);
      scan(1, 2, 40);
      scan(2, 3, 40);
      drive(sel(3), seg_tab[4]);
      meas_lat(lat);
      chk("frame_latency", 32'(lat), 32'd18);
      chk("frame_vcount", 32'(vcount), 32'd1);
      chk("frame_digitos", 32'(digitos), 32'h4321);
      chk("frame_error", 32'(error), 32'h0);
      chk("frame_valid_low_after", 32'(valido), 32'h0);

      // Short dwell on digit 2 blocks completion until it is rescanned.
      scan(0, 5, 40);
      scan(1, 6, 40);
      scan(2, 7, 10);
      scan(3, 8, 40);
      chk("short_no_valid", 32'(vcount), 32'd1);
      chk("short_digitos_held", 32'(digitos), 32'h4321);
      scan(2, 7, 40);
      chk("short_restore_vcount", 32'(vcount), 32'd2);
      chk("short_restore_digitos", 32'(digitos), 32'h8765);

      // Invalid glyph on digit 1: flag set, previous value kept.
      scan(0, 9, 40);
      drive(sel(1), 7'b1111110);
      repeat (40) @(posedge clk);
      scan(2, 11, 40);
      scan(3, 12, 40);
      chk("inval_vcount", 32'(vcount), 32'd3);
      chk("inval_error", 32'(error), 32'h2);
      chk("inval_digitos", 32'(digitos), 32'hCB69);
      scan(0, 9, 40);
      scan(1, 10, 40);
      scan(2, 11, 40);
      scan(3, 12, 40);
      chk("inval_fix_vcount", 32'(vcount), 32'd4);
      chk("inval_fix_error", 32'(error), 32'h0);
      chk("inval_fix_digitos", 32'(digitos), 32'hCBA9);

      // One-cycle segment glitch on the last digit of a frame restarts settling.
      scan(1, 2, 40);
      scan(2, 3, 40);
      scan(3, 4, 40);
      drive(sel(0), seg_tab[1]);
      repeat (10) @(posedge clk);
      drive(sel(0), 7'h7F);
      drive(sel(0), seg_tab[1]);
      meas_lat(lat);
      chk("glitch_latency", 32'(lat), 32'd18);
      chk("glitch_vcount", 32'(vcount), 32'd5);
      chk("glitch_digitos", 32'(digitos), 32'h4321);

      // Two anodes low: never a capture.
      scan(2, 7, 40);
      scan(3, 8, 40);
      drive(4'b1100, seg_tab[5]);
      repeat (40) @(posedge clk);
      chk("multi_no_valid", 32'(vcount), 32'd5);
      chk("multi_digitos_held", 32'(digitos), 32'h4321);
      scan(0, 5, 40);
      scan(1, 6, 40);
      chk("multi_then_frame", 32'(vcount), 32'd6);
      chk("multi_then_digitos", 32'(digitos), 32'h8765);

      // Reset mid-frame discards partial progress.
      scan(0, 1, 40);
      scan(1, 2, 40);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_digitos", 32'(digitos), 32'h0);
      chk("midrst_error", 32'(error), 32'h0);
      rst_n = 1'b1;
      scan(2, 3, 40);
      scan(3, 4, 40);
      chk("midrst_no_valid", 32'(vcount), 32'd6);
      chk("midrst_digitos_zero", 32'(digitos), 32'h0);
      scan(0, 1, 40);
      scan(1, 2, 40);
      chk("midrst_frame_vcount", 32'(vcount), 32'd7);
      chk("midrst_frame_digitos", 32'(digitos), 32'h4321);

      chk("valid_never_double", 32'(dbl), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
